axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
//  AXI4 initiator (master) that turns single-command requests into one INCR/FIXED/WRAP burst on a full AXI4 port.
//  Sits between the test/control logic and axi_ram-class slaves; each command is a read or write of 1..256 beats.
//  Write data is streamed in and read data is streamed out, with a ready/valid handshake on each stream.
//  One transaction is in flight at a time; completion is reported with the captured BRESP or worst RRESP.
// PARAMETERS
//  DATA_WIDTH  32            data bus width in bits, power of two, >=8
//  ADDR_WIDTH  16            address bus width in bits
//  ID_WIDTH    8             AXI ID width
//  STRB_WIDTH  DATA_WIDTH/8  byte-strobe width
//  AXI_ID      0             constant ID driven on awid/arid
// PORTS
//  m_axi_aclk     in   1                     sole clock, rising edge
//  m_axi_areset   in   1                     synchronous, active-high reset
//  cmd_valid/cmd_ready  in/out 1             command handshake
//  cmd_write      in   1                     1=write burst, 0=read burst
//  cmd_addr       in   ADDR_WIDTH            start byte address
//  cmd_len        in   `AXI_BURST_LEN_WIDTH  beats-1 (AxLEN)
//  cmd_burst      in   `AXI_BURST_TYPE_WIDTH 00 FIXED, 01 INCR, 10 WRAP
//  cmd_strb       in   STRB_WIDTH            wstrb used for every beat of a write
//  wr_data/wr_valid/wr_ready  in/in/out DATA_WIDTH/1/1   write-data stream
//  rd_data/rd_valid/rd_ready/rd_last  out/out/in/out DATA_WIDTH/1/1/1   read-data stream
//  done           out  1                     1-cycle pulse at end of transaction
//  done_resp      out  `AXI_RESP_WIDTH       response for that transaction, valid with done
//  busy           out  1                     transaction in flight
//  perf_wr_beats, perf_rd_beats  out 32 each  beat counters (see CONFIGURATION)
//  m_axi_aw*/w*/b*/ar*/r*  full AXI4 master port, same set and widths as the axi_ram slave port, m_ prefix
// BEHAVIOUR
//  Reset values: every *valid 0, cmd_ready 0, wr_ready 0, rd_valid 0, done 0, busy 0, bready 0, rready 0, done_resp 0, counters 0.
//  Reset mid-burst: state returns to IDLE on the next edge, all valids drop and no done is issued; the slave is reset alongside.
//  Constant outputs: awsize/arsize=$clog2(STRB_WIDTH), awid/arid=AXI_ID, prot/cache/lock/qos/region=0.
//  States: IDLE -> AW -> W -> B -> DONE -> IDLE for writes; IDLE -> AR -> R -> DONE -> IDLE for reads.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register all cmd_* fields, clear beat_cnt and rresp_acc, then go to AW or AR.
//  AW/AR: valid held high with stable fields until ready is sampled high, never dropped early. Handshake -> W / R next cycle.
//  W: wvalid=wr_valid, wr_ready=m_axi_wready, wdata=wr_data, wstrb=cmd_strb (combinational passthrough).
//    wlast=(beat_cnt==len). Each beat advances beat_cnt; the beat with wlast goes to B.
//  B: bready=1; on bvalid, latch bresp -> DONE. bid is not checked.
//  R: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=(beat_cnt==len).
//    rresp_acc=max(rresp_acc,rresp) on each beat. The beat with beat_cnt==len goes to DONE.
//    beat_cnt is authoritative and slave rlast is ignored.
//  DONE: done=1 for one cycle, done_resp = latched bresp or rresp_acc, busy drops -> IDLE. Next command accepted on the following cycle.
//  Latency: cmd accept to awvalid/arvalid is 1 cycle; last handshake to done is 1 cycle.
//  beat_cnt is 9 bits wide, so len=255 gives 256 beats with no wrap. len=0 is a single beat with wlast/rd_last on that beat.
//  A wr_valid that is already high on entry to W is consumed in the first W cycle. No bubbles are inserted between beats.
//  Addresses are not generated per beat; address stepping is the slave's job.
// CONFIGURATION
//  `AXI_MASTER_PERF_CNT_EN defined:
//    perf_wr_beats counts every W handshake and perf_rd_beats every R handshake. Both are 32-bit, wrap at 2^32, cleared only by reset.
//  Not defined: both outputs are tied to 32'd0 and the counter logic is not synthesised. All other behaviour is identical.
// TESTING
//  Write len=3 INCR addr 0x10 strb 0xF, data 0x11111111..0x44444444 -> 4 W beats, wlast on beat 4 only, done with done_resp=00.
//  Then read len=3 INCR addr 0x10 -> rd_data 0x11111111..0x44444444 in order, rd_last on 4th, done_resp=00.
//  Write len=0 addr 0x0 strb 0x3 data 0xAABBCCDD over word 0x12345678 -> readback 0x1234CCDD.
//  Hold rd_ready=0 for 5 cycles mid-read -> rready=0, slave holds the beat, no data lost, beat_cnt frozen.
//  cmd_valid during a burst -> cmd_ready=0 and the command is accepted only after the done pulse.
//  Assert m_axi_areset during W beat 2 -> next cycle all valids=0, busy=0, no done.
//  After reset a new len=3 write completes.
//  With AXI_MASTER_PERF_CNT_EN: after the first two scenarios -> perf_wr_beats=4 and perf_rd_beats=4.
//  Without it: both read 0.

Source files
------------

// File: rtl/axi_burst_master.sv
// axi_burst_master
//   AXI4 initiator that converts one command into one FIXED/INCR/WRAP burst
//   of 1..256 beats. One transaction is in flight at a time. Write data is
//   streamed in on wr_*, read data streamed out on rd_*, both ready/valid.
//   Completion is a one-cycle done pulse carrying BRESP (writes) or the
//   worst RRESP seen across the burst (reads).
//
// Ports
//   m_axi_aclk, m_axi_areset      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/addr/len/burst/strb command fields (len = beats-1)
//   wr_data/wr_valid/wr_ready     write-data stream in
//   rd_data/rd_valid/rd_ready/rd_last  read-data stream out
//   done, done_resp, busy         completion and status
//   perf_wr_beats, perf_rd_beats  W / R handshake counters
//   m_axi_*                       full AXI4 master port
//
// Configuration
//   AXI_MASTER_PERF_CNT_EN  when defined, the perf counters count W and R
//                           handshakes; otherwise both read as zero.

`ifndef AXI_BURST_LEN_WIDTH
`define AXI_BURST_LEN_WIDTH 8
`endif
`ifndef AXI_BURST_TYPE_WIDTH
`define AXI_BURST_TYPE_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_burst_master #(
  parameter int                DATA_WIDTH = 32,
  parameter int                ADDR_WIDTH = 16,
  parameter int                ID_WIDTH   = 8,
  parameter int                STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
  input  logic                             m_axi_aclk,
  input  logic                             m_axi_areset,
  // command
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [`AXI_BURST_LEN_WIDTH-1:0]  cmd_len,
  input  logic [`AXI_BURST_TYPE_WIDTH-1:0] cmd_burst,
  input  logic [STRB_WIDTH-1:0]            cmd_strb,
  // write-data stream
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  // read-data stream
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic                             rd_last,
  // status
  output logic                             done,
  output logic [`AXI_RESP_WIDTH-1:0]       done_resp,
  output logic                             busy,
  output logic [31:0]                      perf_wr_beats,
  output logic [31:0]                      perf_rd_beats,
  // AXI4 write address
  output logic [ID_WIDTH-1:0]              m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [`AXI_BURST_LEN_WIDTH-1:0]  m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [`AXI_BURST_TYPE_WIDTH-1:0] m_axi_awburst,
  output logic                             m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic [3:0]                       m_axi_awqos,
  output logic [3:0]                       m_axi_awregion,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  // AXI4 write data
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [STRB_WIDTH-1:0]            m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  // AXI4 write response
  input  logic [ID_WIDTH-1:0]              m_axi_bid,
  input  logic [`AXI_RESP_WIDTH-1:0]       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  // AXI4 read address
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [`AXI_BURST_LEN_WIDTH-1:0]  m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [`AXI_BURST_TYPE_WIDTH-1:0] m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic [3:0]                       m_axi_arqos,
  output logic [3:0]                       m_axi_arregion,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  // AXI4 read data
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [`AXI_RESP_WIDTH-1:0]       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]            addr;
    logic [`AXI_BURST_LEN_WIDTH-1:0]  len;
    logic [`AXI_BURST_TYPE_WIDTH-1:0] burst;
    logic [STRB_WIDTH-1:0]            strb;
  } cmd_t;

  state_t                      state, state_nxt;
  cmd_t                        cmd_q;
  // one bit wider than len so a 256-beat burst never wraps the count
  logic [8:0]                  beat_cnt;
  logic [`AXI_RESP_WIDTH-1:0]  resp_q;
  logic                        last_beat;
  logic                        cmd_hs, w_hs, r_hs;

  // bid/rid are not checked and slave rlast is ignored: beat_cnt decides
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  assign last_beat = (beat_cnt == {1'b0, cmd_q.len});
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;

  // constant / registered address-channel fields
  assign m_axi_awid     = AXI_ID;
  assign m_axi_awaddr   = cmd_q.addr;
  assign m_axi_awlen    = cmd_q.len;
  assign m_axi_awsize   = AXSIZE;
  assign m_axi_awburst  = cmd_q.burst;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'd0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_arid     = AXI_ID;
  assign m_axi_araddr   = cmd_q.addr;
  assign m_axi_arlen    = cmd_q.len;
  assign m_axi_arsize   = AXSIZE;
  assign m_axi_arburst  = cmd_q.burst;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'd0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;

  // data passthrough; only qualified by the valid/ready muxing below
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = cmd_q.strb;
  assign rd_data     = m_axi_rdata;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    done_resp     = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        // held low while reset is asserted so the reset value is clean
        cmd_ready = ~m_axi_areset;
        if (cmd_hs) state_nxt = cmd_write ? S_AW : S_AR;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = last_beat;
        if (w_hs && last_beat) state_nxt = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = S_DONE;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = S_R;
      end
      S_R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        rd_last      = last_beat;
        if (r_hs && last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        done_resp = resp_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      cmd_q    <= '0;
      beat_cnt <= '0;
      resp_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (cmd_hs) begin
          cmd_q    <= '{addr: cmd_addr, len: cmd_len, burst: cmd_burst, strb: cmd_strb};
          beat_cnt <= '0;
          resp_q   <= '0;
        end
        S_W: if (w_hs) beat_cnt <= beat_cnt + 9'd1;
        S_B: if (m_axi_bvalid) resp_q <= m_axi_bresp;
        S_R: if (r_hs) begin
          beat_cnt <= beat_cnt + 9'd1;
          // worst response wins; AXI encodings are ordered by severity
          if (m_axi_rresp > resp_q) resp_q <= m_axi_rresp;
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_MASTER_PERF_CNT_EN
  logic [31:0] perf_wr_q, perf_rd_q;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      perf_wr_q <= '0;
      perf_rd_q <= '0;
    end else begin
      if (w_hs) perf_wr_q <= perf_wr_q + 32'd1;
      if (r_hs) perf_rd_q <= perf_rd_q + 32'd1;
    end
  end

  assign perf_wr_beats = perf_wr_q;
  assign perf_rd_beats = perf_rd_q;
`else
  assign perf_wr_beats = 32'd0;
  assign perf_rd_beats = 32'd0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI4 memory slave, a reference
// memory model, and queue scoreboards for W beats, read beats and done
// responses. Table of commands plus hand sequences for stalls, command
// blocking during a burst and reset mid-burst.

module tb_axi_burst_master;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_strb;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic        done, busy;
  logic [1:0]  done_resp;
  logic [31:0] perf_wr_beats, perf_rd_beats;

  logic [7:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  axi_burst_master dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_strb(cmd_strb),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .busy(busy),
    .perf_wr_beats(perf_wr_beats), .perf_rd_beats(perf_rd_beats),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  wire unused_tb = ^{awid, arid, awlen, arlen, arsize, awprot, arprot, awlock, arlock,
                     awcache, arcache, awqos, arqos, awregion, arregion, wstrb};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'h12345678 ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural AXI4 memory slave ----------------
  logic [31:0] mem [0:255];
  logic        mem_inited = 1'b0;
  logic        s_wact, s_bv, s_ract;
  logic [15:0] s_waddr, s_raddr;
  logic [1:0]  s_wburst, s_rburst;
  logic [7:0]  s_rleft, s_rbeat;
  logic [1:0]  bresp_k;
  logic [7:0]  rresp_pat;   // 2 bits per beat, indexed by beat mod 4

  assign awready = !s_wact && !s_bv;
  assign wready  = s_wact;
  assign bvalid  = s_bv;
  assign bresp   = bresp_k;
  assign bid     = 8'd0;
  assign arready = !s_ract;
  assign rvalid  = s_ract;
  assign rdata   = mem[s_raddr[9:2]];
  assign rresp   = rresp_pat[{s_rbeat[1:0], 1'b0} +: 2];
  assign rlast   = (s_rleft == 8'd0);
  assign rid     = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      s_wact <= 1'b0; s_bv <= 1'b0; s_ract <= 1'b0;
      s_waddr <= '0; s_raddr <= '0; s_wburst <= '0; s_rburst <= '0;
      s_rleft <= '0; s_rbeat <= '0;
      if (!mem_inited) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        mem_inited <= 1'b1;
      end
    end else begin
      if (awvalid && awready) begin
        s_wact <= 1'b1; s_waddr <= awaddr; s_wburst <= awburst;
      end
      if (wvalid && wready) begin
        mem[s_waddr[9:2]] <= merge(mem[s_waddr[9:2]], wdata, wstrb);
        if (s_wburst != 2'b00) s_waddr <= s_waddr + 16'd4;
        if (wlast) begin s_wact <= 1'b0; s_bv <= 1'b1; end
      end
      if (s_bv && bready) s_bv <= 1'b0;
      if (arvalid && arready) begin
        s_ract <= 1'b1; s_raddr <= araddr; s_rleft <= arlen;
        s_rburst <= arburst; s_rbeat <= '0;
      end
      if (rvalid && rready) begin
        s_rbeat <= s_rbeat + 8'd1;
        if (s_rburst != 2'b00) s_raddr <= s_raddr + 16'd4;
        if (s_rleft == 8'd0) s_ract <= 1'b0;
        else                 s_rleft <= s_rleft - 8'd1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] d; logic last; } beat_t;
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0, dstep;
    logic [1:0]  bresp, exp_resp;
    logic [7:0]  rpat;
  } vec_t;

  beat_t       exp_w[$], exp_r[$];
  logic [1:0]  exp_resp[$];
  logic [31:0] wdat[$];
  logic [31:0] ref_mem [0:255];
  int          nerr = 0, nchk = 0, done_cnt = 0, rd_seen = 0;
  bit          blk = 1'b0;
  vec_t        tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic prep(input vec_t v);
    logic [15:0] a;
    logic [31:0] d;
    a = v.addr; d = v.d0;
    exp_resp.push_back(v.exp_resp);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (v.wr) begin
        wdat.push_back(d);
        exp_w.push_back('{d: d, last: (i == int'(v.len))});
        ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, v.strb);
        d = d + v.dstep;
      end else begin
        exp_r.push_back('{d: ref_mem[a[9:2]], last: (i == int'(v.len))});
      end
      if (v.burst != 2'b00) a = a + 16'd4;
    end
  endtask

  task automatic set_cmd(input vec_t v);
    cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    cmd_burst = v.burst; cmd_strb = v.strb;
    bresp_k = v.bresp; rresp_pat = v.rpat;
  endtask

  task automatic issue_cmd(input vec_t v);
    bit hs;
    int n;
    set_cmd(v);
    cmd_valid = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 200) begin
      @(negedge clk); hs = cmd_ready;
      tick(); n++;
    end
    cmd_valid = 1'b0;
    if (!hs) chk("cmd_accept_timeout", 32'(hs), 32'd1);
  endtask

  task automatic stream_w();
    bit hs;
    int n;
    while (wdat.size() > 0) begin
      wr_valid = 1'b1; wr_data = wdat.pop_front();
      hs = 1'b0; n = 0;
      while (!hs && n < 200) begin
        @(negedge clk); hs = wr_ready;
        tick(); n++;
      end
      if (!hs) begin chk("wbeat_timeout", 32'(hs), 32'd1); wdat.delete(); end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int lim);
    int n;
    n = 0;
    while (done_cnt < target && n < lim) begin @(posedge clk); n++; end
    #1;
    chk("done_seen", 32'(done_cnt >= target), 32'd1);
    chk("exp_w_drained", 32'(exp_w.size()), 32'd0);
    chk("exp_r_drained", 32'(exp_r.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n0;
    n0 = done_cnt;
    prep(v);
    issue_cmd(v);
    if (v.wr) stream_w();
    wait_done(n0 + 1, 2000);
  endtask

  initial begin
    vec_t wv, rv;
    int   n0, n;
    bit   acc, saw_done;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_burst = 2'b01; cmd_strb = 4'hF; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
    bresp_k = 2'b00; rresp_pat = 8'h00;

    //            wr    addr      len    burst  strb   d0            dstep         bresp  exp    rpat
    tbl[0] = '{1'b1, 16'h0010, 8'd3,   2'b01, 4'hF, 32'h11111111, 32'h11111111, 2'b00, 2'b00, 8'h00};
    tbl[1] = '{1'b0, 16'h0010, 8'd3,   2'b01, 4'hF, 32'h0,        32'h0,        2'b00, 2'b00, 8'h00};
    tbl[2] = '{1'b1, 16'h0000, 8'd0,   2'b01, 4'h3, 32'hAABBCCDD, 32'h0,        2'b00, 2'b00, 8'h00};
    tbl[3] = '{1'b0, 16'h0000, 8'd0,   2'b01, 4'hF, 32'h0,        32'h0,        2'b00, 2'b00, 8'h00};
    tbl[4] = '{1'b0, 16'h0010, 8'd3,   2'b01, 4'hF, 32'h0,        32'h0,        2'b00, 2'b01, 8'h04};
    tbl[5] = '{1'b0, 16'h0010, 8'd3,   2'b01, 4'hF, 32'h0,        32'h0,        2'b00, 2'b11, 8'hB4};
    tbl[6] = '{1'b1, 16'h0000, 8'd255, 2'b01, 4'hF, 32'hC0DE0000, 32'h00010003, 2'b10, 2'b10, 8'h00};
    tbl[7] = '{1'b0, 16'h0000, 8'd255, 2'b01, 4'hF, 32'h0,        32'h0,        2'b00, 2'b00, 8'h00};
    tbl[8] = '{1'b1, 16'h0040, 8'd2,   2'b00, 4'hF, 32'h5A5A0000, 32'h1,        2'b01, 2'b01, 8'h00};
    tbl[9] = '{1'b0, 16'h0040, 8'd2,   2'b00, 4'hF, 32'h0,        32'h0,        2'b00, 2'b00, 8'h00};

    // monitor: compares DUT outputs against the queues on the falling edge
    fork
      forever begin
        beat_t e;
        @(negedge clk);
        if (!rst) begin
          if (blk) chk("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
          if (wvalid && wready) begin
            if (exp_w.size() == 0) chk("wbeat_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_w.pop_front();
              chk("wdata", wdata, e.d);
              chk("wlast", 32'(wlast), 32'(e.last));
            end
          end
          if (rd_valid && rd_ready) begin
            rd_seen++;
            if (exp_r.size() == 0) chk("rbeat_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_r.pop_front();
              chk("rd_data", rd_data, e.d);
              chk("rd_last", 32'(rd_last), 32'(e.last));
            end
          end
          if (done) begin
            done_cnt++;
            if (exp_resp.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
            else chk("done_resp", 32'(done_resp), 32'(exp_resp.pop_front()));
          end
        end
      end
    join_none

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_resp", 32'(done_resp), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_perf_wr", perf_wr_beats, 32'd0);
    chk("rst_perf_rd", perf_rd_beats, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("awsize", 32'(awsize), 32'd2);
    chk("awid", 32'(awid), 32'd0);

    // ---- command table ----
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i]);
      if (i == 1) begin
`ifdef AXI_MASTER_PERF_CNT_EN
        chk("perf_wr_after_2", perf_wr_beats, 32'd4);
        chk("perf_rd_after_2", perf_rd_beats, 32'd4);
`else
        chk("perf_wr_after_2", perf_wr_beats, 32'd0);
        chk("perf_rd_after_2", perf_rd_beats, 32'd0);
`endif
      end
    end

    // ---- rd_ready stall for 5 cycles after the first beat ----
    rv = tbl[1];
    prep(rv);
    n0 = done_cnt;
    rd_seen = 0;
    rd_ready = 1'b0;
    issue_cmd(rv);
    tick(); tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_rready", 32'(rready), 32'd0);
      chk("stall_rvalid_held", 32'(rvalid), 32'd1);
      chk("stall_beats", 32'(rd_seen), 32'd1);
      tick();
    end
    rd_ready = 1'b1;
    wait_done(n0 + 1, 200);

    // ---- command offered during a write burst ----
    wv = '{1'b1, 16'h0020, 8'd3, 2'b01, 4'hF, 32'hA0000001, 32'h00000010, 2'b00, 2'b00, 8'h00};
    rv = '{1'b0, 16'h0020, 8'd3, 2'b01, 4'hF, 32'h0, 32'h0, 2'b00, 2'b00, 8'h00};
    n0 = done_cnt;
    prep(wv);
    issue_cmd(wv);
    chk("awvalid_latency", 32'(awvalid), 32'd1);
    chk("busy_in_burst", 32'(busy), 32'd1);
    prep(rv);
    set_cmd(rv);
    cmd_valid = 1'b1;
    blk = 1'b1;
    stream_w();
    blk = 1'b0;
    acc = 1'b0; saw_done = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        chk("cmd_after_done", 32'(saw_done), 32'd1);
      end
      if (done) saw_done = 1'b1;
      tick(); n++;
    end
    cmd_valid = 1'b0;
    chk("pending_cmd_accepted", 32'(acc), 32'd1);
    wait_done(n0 + 2, 200);

    // ---- reset during W beat 2 ----
    wv = '{1'b1, 16'h0080, 8'd3, 2'b01, 4'hF, 32'hD0000001, 32'h1, 2'b00, 2'b00, 8'h00};
    n0 = done_cnt;
    issue_cmd(wv);
    wdat.push_back(32'hD0000001);
    exp_w.push_back('{d: 32'hD0000001, last: 1'b0});
    stream_w();
    wr_valid = 1'b1; wr_data = 32'hD0000002;
    rst = 1'b1;
    tick();
    chk("rstmid_awvalid", 32'(awvalid), 32'd0);
    chk("rstmid_wvalid", 32'(wvalid), 32'd0);
    chk("rstmid_arvalid", 32'(arvalid), 32'd0);
    chk("rstmid_rd_valid", 32'(rd_valid), 32'd0);
    chk("rstmid_wr_ready", 32'(wr_ready), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    wr_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_w.delete();
    repeat (4) tick();
    chk("rstmid_no_done", 32'(done_cnt), 32'(n0));
    chk("rstmid_perf_wr", perf_wr_beats, 32'd0);

    // ---- fresh write after reset, then read it back ----
    run_vec(wv);
    rv = '{1'b0, 16'h0080, 8'd3, 2'b01, 4'hF, 32'h0, 32'h0, 2'b00, 2'b00, 8'h00};
    run_vec(rv);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
